vga_fetch_scheduler: RTL
========================

VGA_FETCH_SCHEDULER -- requirements
Module: vga_fetch_scheduler

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH 1024, pixel FIFO depth; BURST_LEN 64, max pixels per DMA command; FRAME_PIXELS 307200, pixels per frame; PIXEL_BYTES 2, memory bytes per pixel.
REQ-002 SHALL have ports: i_CLK in 1, system clock; i_RST_n in 1, reset, asynchronous, active-low.
REQ-003 SHALL have i_ENABLE in 1, run request; i_FRAME_BASE in 32, frame byte base address; i_CLR_STATUS in 1, clears sticky flags.
REQ-004 SHALL have i_VSYNC in 1, VGA vertical sync, active-low level.
REQ-005 SHALL have i_FIFO_LEVEL in 11, FIFO occupancy; i_FIFO_WR in 1, pixel written; i_FIFO_RD in 1, pixel read; i_FIFO_EMPTY in 1.
REQ-006 SHALL have o_CMD_VALID out 1; i_CMD_READY in 1; o_CMD_ADDR out 32; o_CMD_LEN out 16, pixels.
REQ-007 SHALL have o_FIFO_FLUSH out 1; o_FRAME_DONE out 1; o_BUSY out 1; o_UNDERFLOW out 1; o_FRAME_LATE out 1.

Function
REQ-008 SHALL implement states IDLE, WAIT_VSYNC, FLUSH, CHECK, ISSUE, WAIT_DATA, FRAME_END.
REQ-009 IDLE -> WAIT_VSYNC when i_ENABLE=1; o_BUSY=1 in every state except IDLE.
REQ-010 Frame start SHALL be the cycle after i_VSYNC is sampled 1 then 0 (registered falling edge).
REQ-011 WAIT_VSYNC -> FLUSH on frame start; address latched from i_FRAME_BASE, remaining set to FRAME_PIXELS.
REQ-012 FLUSH SHALL assert o_FIFO_FLUSH for exactly one cycle, then go to CHECK.
REQ-013 CHECK: len = min(BURST_LEN, remaining); remaining=0 -> FRAME_END; else FIFO_DEPTH - i_FIFO_LEVEL >= len -> ISSUE; else stay.
REQ-014 ISSUE: o_CMD_VALID=1 with o_CMD_ADDR/o_CMD_LEN stable until i_CMD_READY=1; handshake cycle -> WAIT_DATA.
REQ-015 On handshake: address += len*PIXEL_BYTES (32-bit wrap), remaining -= len.
REQ-016 WAIT_DATA counts i_FIFO_WR pulses; count reaching len -> CHECK next cycle; excess writes ignored.
REQ-017 FRAME_END: o_FRAME_DONE one-cycle pulse; -> WAIT_VSYNC if i_ENABLE=1, else IDLE.
REQ-018 i_ENABLE deasserted mid-frame: issued command completes (WAIT_DATA finishes), then IDLE; no new command issued; no o_FRAME_DONE.
REQ-019 Frame start seen in any state other than WAIT_VSYNC/IDLE SHALL set o_FRAME_LATE; transfer continues unchanged.
REQ-020 i_FIFO_RD=1 with i_FIFO_EMPTY=1 while o_BUSY=1 SHALL set o_UNDERFLOW next cycle.
REQ-021 Sticky flags cleared by i_CLR_STATUS; simultaneous set and clear: set wins.
REQ-022 i_FRAME_BASE changes take effect only at next frame start.

Reset
REQ-023 i_RST_n=0 SHALL immediately force state IDLE, all outputs 0, counters/address/remaining 0.
REQ-024 Reset mid-transfer SHALL abandon the frame; after release a new frame start is required.

Configuration
REQ-025 Macro VGA_FETCH_STATS_EN defined: add o_FRAME_CNT out 16 (increments per o_FRAME_DONE) and o_UNDERFLOW_CNT out 16 (per underflow event), both saturating at 0xFFFF, cleared by reset and i_CLR_STATUS.
REQ-026 Macro undefined: counters not instantiated; ports present, tied to 0.

Structure
REQ-027 Package vga_fetch_pkg SHALL hold the state enum and default parameter constants.
REQ-028 Sub-module vga_sync_edge_detect SHALL register i_VSYNC and produce the frame-start pulse.
REQ-029 Burst-length/free-space compare SHALL stay in the top module.

Verification (FIFO_DEPTH 1024, BURST_LEN 64, FRAME_PIXELS 200, PIXEL_BYTES 2, base 0x1000_0000)
REQ-030 Enable, VSYNC fall, level 0 -> flush 1 cycle; cmds 0x1000_0000/64, 0x1000_0080/64, 0x1000_0100/64, 0x1000_0180/8, each after all writes; then o_FRAME_DONE pulse.
REQ-031 Level 980 in CHECK -> no o_CMD_VALID until level <= 960.
REQ-032 i_CMD_READY low 10 cycles -> o_CMD_VALID, ADDR, LEN stable all 10 cycles.
REQ-033 RD with EMPTY -> o_UNDERFLOW=1 next cycle; clear+new underflow same cycle -> stays 1; clear alone -> 0.
REQ-034 Reset in WAIT_DATA -> all outputs 0 immediately; after release, no command until a new VSYNC fall.
REQ-035 VSYNC fall during WAIT_DATA -> o_FRAME_LATE=1; frame completes with 4 commands.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// Shared state encoding and default sizing for the VGA frame fetch scheduler.
package vga_fetch_pkg;

  localparam int unsigned DefFifoDepth   = 1024;
  localparam int unsigned DefBurstLen    = 64;
  localparam int unsigned DefFramePixels = 307200;
  localparam int unsigned DefPixelBytes  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWaitVsync,
    StFlush,
    StCheck,
    StIssue,
    StWaitData,
    StFrameEnd
  } fetch_state_e;

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Registers VSYNC and flags a frame start the cycle after a sampled 1 -> 0 transition.
module vga_sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic frame_start_o
);

  logic vsync_q;
  logic vsync_prev_q;

  // Both stages reset low so a VSYNC held low across reset release is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      vsync_q      <= vsync_i;
      vsync_prev_q <= vsync_q;
    end
  end

  assign frame_start_o = vsync_prev_q & ~vsync_q;

endmodule

// File: rtl/vga_fetch_scheduler.sv
// Issues per-frame DMA burst commands into a pixel FIFO, gated on free space.
// Optional statistics counters are built when VGA_FETCH_STATS_EN is defined.
module vga_fetch_scheduler
  import vga_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth,
  parameter int unsigned BURST_LEN    = DefBurstLen,
  parameter int unsigned FRAME_PIXELS = DefFramePixels,
  parameter int unsigned PIXEL_BYTES  = DefPixelBytes
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_ENABLE,
  input  logic [31:0] i_FRAME_BASE,
  input  logic        i_CLR_STATUS,
  input  logic        i_VSYNC,
  input  logic [10:0] i_FIFO_LEVEL,
  input  logic        i_FIFO_WR,
  input  logic        i_FIFO_RD,
  input  logic        i_FIFO_EMPTY,
  output logic        o_CMD_VALID,
  input  logic        i_CMD_READY,
  output logic [31:0] o_CMD_ADDR,
  output logic [15:0] o_CMD_LEN,
  output logic        o_FIFO_FLUSH,
  output logic        o_FRAME_DONE,
  output logic        o_BUSY,
  output logic        o_UNDERFLOW,
  output logic        o_FRAME_LATE,
  output logic [15:0] o_FRAME_CNT,
  output logic [15:0] o_UNDERFLOW_CNT
);

  fetch_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic [31:0] remaining_q;
  logic [15:0] len_q;
  logic [15:0] wr_cnt_q;
  logic        busy_q, valid_q, flush_q, done_q, underflow_q, late_q;

  logic        frame_start;
  logic [15:0] len_c;
  logic        room_c;
  logic        underflow_evt;

  vga_sync_edge_detect u_sync_edge (
    .clk_i         (i_CLK),
    .rst_ni        (i_RST_n),
    .vsync_i       (i_VSYNC),
    .frame_start_o (frame_start)
  );

  assign underflow_evt = i_FIFO_RD & i_FIFO_EMPTY & busy_q;

  always_comb begin
    len_c   = (remaining_q < BURST_LEN) ? remaining_q[15:0] : 16'(BURST_LEN);
    // Written as level + len <= depth so an over-reported level cannot wrap the free count.
    room_c  = ({21'd0, i_FIFO_LEVEL} + 32'(len_c)) <= FIFO_DEPTH;
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (i_ENABLE) state_d = StWaitVsync;
      StWaitVsync: begin
        if (!i_ENABLE)        state_d = StIdle;
        else if (frame_start) state_d = StFlush;
      end
      StFlush:     state_d = StCheck;
      StCheck: begin
        if (!i_ENABLE)              state_d = StIdle;
        else if (remaining_q == '0) state_d = StFrameEnd;
        else if (room_c)            state_d = StIssue;
      end
      StIssue:     if (i_CMD_READY) state_d = StWaitData;
      StWaitData: begin
        if (i_FIFO_WR && (wr_cnt_q + 16'd1 == len_q)) begin
          state_d = i_ENABLE ? StCheck : StIdle;
        end
      end
      StFrameEnd:  state_d = i_ENABLE ? StWaitVsync : StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      valid_q <= (state_d == StIssue);
      flush_q <= (state_d == StFlush);
      done_q  <= (state_d == StFrameEnd);

      if (state_q == StWaitVsync && state_d == StFlush) begin
        addr_q      <= i_FRAME_BASE;
        remaining_q <= 32'(FRAME_PIXELS);
      end else if (state_q == StCheck && state_d == StIssue) begin
        len_q <= len_c;
      end else if (state_q == StIssue && i_CMD_READY) begin
        addr_q      <= addr_q + 32'(len_q) * PIXEL_BYTES;
        remaining_q <= remaining_q - 32'(len_q);
        wr_cnt_q    <= '0;
      end else if (state_q == StWaitData && i_FIFO_WR) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end

      // Sticky flags: a new event in the clearing cycle keeps the flag set.
      underflow_q <= underflow_evt | (underflow_q & ~i_CLR_STATUS);
      late_q      <= (frame_start && state_q != StIdle && state_q != StWaitVsync) |
                     (late_q & ~i_CLR_STATUS);
    end
  end

  assign o_CMD_VALID  = valid_q;
  assign o_CMD_ADDR   = addr_q;
  assign o_CMD_LEN    = len_q;
  assign o_FIFO_FLUSH = flush_q;
  assign o_FRAME_DONE = done_q;
  assign o_BUSY       = busy_q;
  assign o_UNDERFLOW  = underflow_q;
  assign o_FRAME_LATE = late_q;

`ifdef VGA_FETCH_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] underflow_cnt_q;
  logic        frame_evt;

  assign frame_evt = (state_d == StFrameEnd);

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      frame_cnt_q     <= '0;
      underflow_cnt_q <= '0;
    end else if (i_CLR_STATUS) begin
      frame_cnt_q     <= {15'd0, frame_evt};
      underflow_cnt_q <= {15'd0, underflow_evt};
    end else begin
      if (frame_evt && frame_cnt_q != 16'hFFFF)         frame_cnt_q     <= frame_cnt_q + 16'd1;
      if (underflow_evt && underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 16'd1;
    end
  end

  assign o_FRAME_CNT     = frame_cnt_q;
  assign o_UNDERFLOW_CNT = underflow_cnt_q;
`else
  assign o_FRAME_CNT     = 16'd0;
  assign o_UNDERFLOW_CNT = 16'd0;
`endif

endmodule
